// File: rtl/flap_game_sequencer.sv
// Game-flow controller for the flappy-bird game: phase FSM, animator gating,
// score / best score and scroll-speed registers.
module flap_game_sequencer #(
   parameter int READY_FRAMES  = 120,
   parameter int DYING_FRAMES  = 60,
   parameter int BLINK_FRAMES  = 8,
   parameter int SCORE_STEP    = 5,
   parameter int SPEEDUP_EVERY = 4,
   parameter int MAX_SPEED     = 7
) (
   input  logic       CLOCK,
   input  logic       reset,
   input  logic       frameTick,
   input  logic       startBtn_n,
   input  logic       flapBtn_n,
   input  logic       pipePassed,
   input  logic       collision,
   output logic [2:0] gameState,
   output logic       runEnable,
   output logic       birdHold,
   output logic       blankBird,
   output logic [9:0] score,
   output logic [9:0] bestScore,
   output logic       newBest,
   output logic [2:0] scrollSpeed
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] READY   = 3'd1;
   localparam logic [2:0] PLAYING = 3'd2;
   localparam logic [2:0] DYING   = 3'd3;
   localparam logic [2:0] OVER    = 3'd4;

   localparam int CMAX = (READY_FRAMES > DYING_FRAMES) ? READY_FRAMES : DYING_FRAMES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int BW   = $clog2(BLINK_FRAMES + 1);
   localparam int PW   = $clog2(SPEEDUP_EVERY + 1);

   // Buttons are inverted up front so every input acts on a rising edge.
   logic [4:0]       raw;
   logic [1:0][4:0]  sync_pipe;
   logic [4:0]       prev_q;
   logic [4:0]       rise;
   logic             start_p, flap_p, pass_p, frame_p, coll_s;

   assign raw     = {collision, frameTick, pipePassed, ~flapBtn_n, ~startBtn_n};
   assign rise    = sync_pipe[1] & ~prev_q;
   assign start_p = rise[0];
   assign flap_p  = rise[1];
   assign pass_p  = rise[2];
   assign frame_p = rise[3];
   assign coll_s  = sync_pipe[1][4];

   always_ff @(posedge CLOCK or posedge reset) begin
      if (reset) begin
         sync_pipe <= '0;
         prev_q    <= '0;
      end else begin
         sync_pipe <= {sync_pipe[0], raw};
         prev_q    <= sync_pipe[1];
      end
   end

   logic [CW-1:0] cnt, cnt_inc;
   logic [BW-1:0] blink_cnt, blink_inc;
   logic [PW-1:0] pipe_cnt, pipe_inc;
   logic [10:0]   score_sum;
   logic [2:0]    st_nxt;

   assign cnt_inc   = cnt + 1'b1;
   assign blink_inc = blink_cnt + 1'b1;
   assign pipe_inc  = pipe_cnt + 1'b1;
   assign score_sum = {1'b0, score} + 11'(SCORE_STEP);

   always_comb begin
      st_nxt = gameState;
      case (gameState)
         IDLE, OVER: if (start_p) st_nxt = READY;
         READY:      if (flap_p || (frame_p && cnt_inc == CW'(READY_FRAMES))) st_nxt = PLAYING;
         PLAYING:    if (frame_p && coll_s) st_nxt = DYING;
         DYING:      if (frame_p && cnt_inc == CW'(DYING_FRAMES)) st_nxt = OVER;
         default:    st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or posedge reset) begin
      if (reset) begin
         gameState   <= IDLE;
         runEnable   <= 1'b0;
         birdHold    <= 1'b1;
         blankBird   <= 1'b0;
         score       <= '0;
         bestScore   <= '0;
         newBest     <= 1'b0;
         scrollSpeed <= 3'd1;
         cnt         <= '0;
         blink_cnt   <= '0;
         pipe_cnt    <= '0;
      end else begin
         gameState <= st_nxt;
         runEnable <= (st_nxt == PLAYING);
         birdHold  <= (st_nxt == IDLE) || (st_nxt == READY) || (st_nxt == OVER);
         case (gameState)
            IDLE, OVER: begin
               if (start_p) begin
                  score       <= '0;
                  newBest     <= 1'b0;
                  pipe_cnt    <= '0;
                  cnt         <= '0;
                  scrollSpeed <= 3'd1;
                  blankBird   <= 1'b0;
               end
            end
            READY: begin
               if (st_nxt == PLAYING) cnt <= '0;
               else if (frame_p)      cnt <= cnt_inc;
            end
            PLAYING: begin
               // A collision frame wins over a pass on the same edge.
               if (st_nxt == DYING) begin
                  cnt       <= '0;
                  blink_cnt <= '0;
                  blankBird <= 1'b1;
               end else if (pass_p) begin
                  score <= score_sum[10] ? 10'd1023 : score_sum[9:0];
                  if (pipe_inc == PW'(SPEEDUP_EVERY)) begin
                     pipe_cnt <= '0;
                     if (scrollSpeed < 3'(MAX_SPEED)) scrollSpeed <= scrollSpeed + 1'b1;
                  end else begin
                     pipe_cnt <= pipe_inc;
                  end
               end
            end
            DYING: begin
               if (frame_p) begin
                  if (st_nxt == OVER) begin
                     cnt       <= '0;
                     blankBird <= 1'b0;
                     if (score > bestScore) begin
                        bestScore <= score;
                        newBest   <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt_inc;
                     if (blink_inc == BW'(BLINK_FRAMES)) begin
                        blink_cnt <= '0;
                        blankBird <= ~blankBird;
                     end else begin
                        blink_cnt <= blink_inc;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule
